// File: rtl/pc_fetch_unit_if.sv
// Fetch-unit bus: PC redirect input, instruction-memory request/ack and the decode-side
// valid/ready instruction stream. master = fetch unit, slave = surrounding pipeline/memory.
interface pc_fetch_unit_if #(
  parameter int unsigned PC_W    = 16,
  parameter int unsigned INSTR_W = 32
);
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               inst_valid;
  logic [INSTR_W-1:0] inst_data;
  logic [PC_W-1:0]    inst_pc;
  logic               inst_ready;

  modport master (
    input  redirect_valid, redirect_pc, imem_ack, imem_rdata, inst_ready,
    output imem_req, imem_addr, inst_valid, inst_data, inst_pc
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_ack, imem_rdata, inst_ready,
    input  imem_req, imem_addr, inst_valid, inst_data, inst_pc
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC owner and instruction fetcher: one outstanding imem request, PC-tagged results queued
// for decode. Define FETCH_PERF_EN to add saturating fetch_cnt/flush_cnt outputs.
module pc_fetch_unit #(
  parameter int unsigned     PC_W       = 16,
  parameter int unsigned     INSTR_W    = 32,
  parameter int unsigned     FIFO_DEPTH = 2,
  parameter logic [PC_W-1:0] RESET_PC   = '0
) (
  input  logic            clk,
  input  logic            rst_n,
`ifdef FETCH_PERF_EN
  output logic [15:0]     fetch_cnt,
  output logic [15:0]     flush_cnt,
`endif
  pc_fetch_unit_if.master bus
);
  localparam int unsigned      PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned      CNT_W   = PTR_W + 1;
  localparam int unsigned      ENTRY_W = PC_W + INSTR_W;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StReq, StDrop} state_e;

  state_e             state_q;
  logic [PC_W-1:0]    fetch_pc_q;
  logic               imem_req_q;
  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               valid_q;

  logic             redirect, ack, pop, push;
  logic [CNT_W-1:0] cnt_post_pop, cnt_next;

  always_comb begin
    redirect     = bus.redirect_valid;
    // An ack with no request outstanding is a protocol error and is dropped here.
    ack          = bus.imem_ack & imem_req_q;
    pop          = valid_q & bus.inst_ready;
    push         = (state_q == StReq) & ack & ~redirect;
    cnt_post_pop = cnt_q - CNT_W'(pop);
    cnt_next     = cnt_post_pop + CNT_W'(push);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      imem_req_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {fetch_pc_q, bus.imem_rdata};
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      cnt_q   <= cnt_next;
      valid_q <= (cnt_next != '0);

      // Redirect wins over push/pop: the whole queue is stale.
      if (redirect) begin
        rd_ptr_q   <= '0;
        wr_ptr_q   <= '0;
        cnt_q      <= '0;
        valid_q    <= 1'b0;
        fetch_pc_q <= bus.redirect_pc;
      end

      unique case (state_q)
        StIdle: begin
          if (redirect || (cnt_post_pop < DEPTH_C)) begin
            state_q    <= StReq;
            imem_req_q <= 1'b1;
          end
        end
        StReq: begin
          if (redirect) begin
            if (!ack) state_q <= StDrop;
          end else if (ack) begin
            fetch_pc_q <= fetch_pc_q + PC_W'(1);
            if (cnt_next >= DEPTH_C) begin
              state_q    <= StIdle;
              imem_req_q <= 1'b0;
            end
          end
        end
        StDrop: begin
          if (ack) state_q <= StReq;
        end
        default: begin
          state_q    <= StIdle;
          imem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req   = imem_req_q;
  assign bus.imem_addr  = fetch_pc_q;
  assign bus.inst_valid = valid_q;
  assign bus.inst_data  = mem_q[rd_ptr_q][INSTR_W-1:0];
  assign bus.inst_pc    = mem_q[rd_ptr_q][ENTRY_W-1:INSTR_W];

`ifdef FETCH_PERF_EN
  logic [15:0] fetch_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (push && (fetch_cnt_q != 16'hFFFF)) fetch_cnt_q <= fetch_cnt_q + 16'd1;
      if (redirect && (flush_cnt_q != 16'hFFFF)) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: behavioural imem with per-address latency, expected PCs queued
// per phase and compared against each decode handshake.
module tb_pc_fetch_unit;
  localparam int unsigned PC_W    = 16;
  localparam int unsigned INSTR_W = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  pc_fetch_unit_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

`ifdef FETCH_PERF_EN
  logic [15:0] fetch_cnt, flush_cnt;
`endif

  pc_fetch_unit #(
    .PC_W      (PC_W),
    .INSTR_W   (INSTR_W),
    .FIFO_DEPTH(2),
    .RESET_PC  (16'd0)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef FETCH_PERF_EN
    .fetch_cnt(fetch_cnt),
    .flush_cnt(flush_cnt),
`endif
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          addr_err = 0;
  logic [15:0] exp_q[$];
  bit          slow_en   = 1'b0;
  logic [15:0] slow_addr = 16'd0;
  bit          stray_ack = 1'b0;
  int          mem_cnt   = 0;
  logic [15:0] mem_lat_addr = 16'd0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [15:0] a);
    return {~a, a ^ 16'h5A5A};
  endfunction

  function automatic int lat_for(input logic [15:0] a);
    return (slow_en && (a == slow_addr)) ? 3 : 1;
  endfunction

  // Memory: latches the address when a request is first seen, acks after lat_for() cycles.
  initial begin
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      bus.imem_ack = 1'b0;
      if (rst_n !== 1'b1) begin
        mem_cnt = 0;
        if (stray_ack) begin
          bus.imem_ack   = 1'b1;
          bus.imem_rdata = 32'hDEADBEEF;
          stray_ack      = 1'b0;
        end
      end else if (bus.imem_req === 1'b1) begin
        if (mem_cnt == 0) mem_lat_addr = bus.imem_addr;
        mem_cnt++;
        if (mem_cnt >= lat_for(mem_lat_addr)) begin
          bus.imem_ack   = 1'b1;
          bus.imem_rdata = instr_of(mem_lat_addr);
          mem_cnt        = 0;
        end
      end else begin
        mem_cnt = 0;
      end
    end
  end

  // Decode side: ready only while expectations are pending; each handshake is scored.
  initial begin
    bus.inst_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus.inst_valid === 1'b1 && bus.inst_ready && !bus.redirect_valid) begin
        if (exp_q.size() == 0) begin
          check("sb_extra_pop", 64'(exp_q.size()), 64'd1);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          check("sb_pc", 64'(bus.inst_pc), 64'(e));
          check("sb_data", 64'(bus.inst_data), 64'(instr_of(e)));
        end
      end
      @(posedge clk); #1;
      bus.inst_ready = (exp_q.size() != 0);
    end
  end

  // Address must hold while a request is pending with no ack, redirect or reset.
  initial begin
    bit          p_ok;
    logic [15:0] p_addr;
    forever begin
      @(negedge clk);
      p_ok   = (rst_n === 1'b1) && (bus.imem_req === 1'b1) && !bus.imem_ack
               && !bus.redirect_valid;
      p_addr = bus.imem_addr;
      @(posedge clk); #1;
      if (p_ok && rst_n === 1'b1 && bus.imem_addr !== p_addr) addr_err++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse_redirect(input logic [15:0] pc);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
    @(posedge clk); #2;
    bus.redirect_valid = 1'b0;
  endtask

  task automatic wait_req(input string tag, input logic [15:0] a, input bit need_ack,
                          input int bound);
    int i = 0;
    while (!(bus.imem_req && bus.imem_addr == a && (!need_ack || bus.imem_ack)) && i < bound) begin
      @(posedge clk); #2;
      i++;
    end
    if (i >= bound) begin
      check(tag, {46'd0, bus.imem_req, bus.imem_ack | ~need_ack, bus.imem_addr},
            {46'd0, 1'b1, 1'b1, a});
    end
  endtask

  task automatic wait_drain(input string tag, input int bound);
    int i = 0;
    while (exp_q.size() != 0 && i < bound) begin
      @(posedge clk); #2;
      i++;
    end
    if (exp_q.size() != 0) check(tag, 64'(exp_q.size()), 64'd0);
    else cycles(1);
  endtask

  task automatic reset_dut();
    @(posedge clk); #2;
    rst_n = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_imem_req"}, 64'(bus.imem_req), 64'd0);
    check({tag, "_imem_addr"}, 64'(bus.imem_addr), 64'd0);
    check({tag, "_inst_valid"}, 64'(bus.inst_valid), 64'd0);
    check({tag, "_inst_data"}, 64'(bus.inst_data), 64'd0);
    check({tag, "_inst_pc"}, 64'(bus.inst_pc), 64'd0);
`ifdef FETCH_PERF_EN
    check({tag, "_fetch_cnt"}, 64'(fetch_cnt), 64'd0);
    check({tag, "_flush_cnt"}, 64'(flush_cnt), 64'd0);
`endif
  endtask

  initial begin
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;

    // A: sequential fetch with decode always ready.
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("A_rst");
    for (int i = 0; i < 6; i++) exp_q.push_back(16'(i));
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    wait_drain("A_drain", 100);
    cycles(10);
    check("A_stall_req", 64'(bus.imem_req), 64'd0);
    check("A_stall_valid", 64'(bus.inst_valid), 64'd1);
    check("A_stall_head_pc", 64'(bus.inst_pc), 64'd6);

    // B: decode stalled from reset; exactly two entries then idle.
    reset_dut();
    cycles(10);
    check("B_idle_req", 64'(bus.imem_req), 64'd0);
    check("B_head_valid", 64'(bus.inst_valid), 64'd1);
    check("B_head_pc", 64'(bus.inst_pc), 64'd0);
    check("B_head_data", 64'(bus.inst_data), 64'(instr_of(16'd0)));
    for (int i = 0; i < 4; i++) exp_q.push_back(16'(i));
    wait_drain("B_drain", 100);

    // C: redirect while request for PC 5 is still waiting on a slow ack.
    slow_en   = 1'b1;
    slow_addr = 16'd5;
    cycles(10);
    pulse_redirect(16'd4);
    wait_req("C_wait_req5", 16'd5, 1'b0, 10);
    check("C_pre_valid", 64'(bus.inst_valid), 64'd1);
    check("C_pre_pc", 64'(bus.inst_pc), 64'd4);
    pulse_redirect(16'h0040);
    check("C_flush_valid", 64'(bus.inst_valid), 64'd0);
    check("C_drop_req", 64'(bus.imem_req), 64'd1);
    check("C_drop_addr", 64'(bus.imem_addr), 64'h0040);
    exp_q.push_back(16'h0040);
    exp_q.push_back(16'h0041);
    wait_drain("C_drain", 100);

    // D: redirect in the same cycle as the ack for PC 3.
    slow_addr = 16'd3;
    cycles(10);
    pulse_redirect(16'd3);
    wait_req("D_wait_ack3", 16'd3, 1'b1, 10);
    pulse_redirect(16'h0010);
    check("D_flush_valid", 64'(bus.inst_valid), 64'd0);
    check("D_req", 64'(bus.imem_req), 64'd1);
    check("D_addr", 64'(bus.imem_addr), 64'h0010);
    exp_q.push_back(16'h0010);
    exp_q.push_back(16'h0011);
    wait_drain("D_drain", 100);

    // E: PC wraps past 16'hFFFF.
    slow_en = 1'b0;
    cycles(10);
    pulse_redirect(16'hFFFE);
    exp_q.push_back(16'hFFFE);
    exp_q.push_back(16'hFFFF);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0001);
    wait_drain("E_drain", 100);

    // F: async reset with one queued entry and a fetch outstanding, then a stray ack in IDLE.
    slow_en   = 1'b1;
    slow_addr = 16'd1;
    reset_dut();
    wait_req("F_wait_req1", 16'd1, 1'b0, 10);
    check("F_pre_valid", 64'(bus.inst_valid), 64'd1);
    check("F_pre_pc", 64'(bus.inst_pc), 64'd0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("F_rst");
    stray_ack = 1'b1;
    @(posedge clk); #2;
    rst_n   = 1'b1;
    slow_en = 1'b0;
    exp_q.push_back(16'd0);
    exp_q.push_back(16'd1);
    exp_q.push_back(16'd2);
    wait_drain("F_drain", 100);

    check("addr_stable_violations", 64'(addr_err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
